// File: rtl/bp_trace_decoder_if.sv
// Trace-decoder bus: the trace-FIFO drain side and the record output side.
// master = host/bench side that feeds packets and consumes records.
// slave  = the decoder itself.
interface bp_trace_decoder_if #(
  parameter int vaddr_width_p = 39,
  parameter int trace_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int count_width_p = 16
);
  logic [trace_width_p-1:0] trace_data_i;
  logic                     trace_v_i;
  logic                     trace_ready_o;
  logic [vaddr_width_p-1:0] record_pc_o;
  logic [instr_width_p-1:0] record_instr_o;
  logic [count_width_p-1:0] record_seq_o;
  logic                     record_v_o;
  logic                     record_ready_i;

  modport master (
    output trace_data_i, trace_v_i, record_ready_i,
    input  trace_ready_o, record_pc_o, record_instr_o, record_seq_o, record_v_o
  );

  modport slave (
    input  trace_data_i, trace_v_i, record_ready_i,
    output trace_ready_o, record_pc_o, record_instr_o, record_seq_o, record_v_o
  );
endinterface

// File: rtl/bp_trace_decoder.sv
// Commit-trace decoder: turns SYNC/INSTR/JUMP trace packets into a stream of
// (PC, instruction, sequence) records through a single registered output slot.
module bp_trace_decoder #(
  parameter int vaddr_width_p = 39,
  parameter int trace_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_trace_decoder_if.slave        bus_if,
  output logic                     synced_o,
  output logic                     error_o,
  output logic [count_width_p-1:0] drop_count_o
);

  localparam logic [1:0] PKT_SYNC  = 2'b00;
  localparam logic [1:0] PKT_INSTR = 2'b01;
  localparam logic [1:0] PKT_JUMP  = 2'b10;

  typedef enum logic {ST_UNSYNCED = 1'b0, ST_SYNCED = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [vaddr_width_p-1:0] r_pc;
  logic [vaddr_width_p-1:0] w_pc_next;
  logic [count_width_p-1:0] r_seq;
  logic [count_width_p-1:0] r_drop;
  logic                     r_error;
  logic                     r_rec_v;
  logic [vaddr_width_p-1:0] r_rec_pc;
  logic [instr_width_p-1:0] r_rec_instr;
  logic [count_width_p-1:0] r_rec_seq;

  logic                     w_ready;
  logic                     w_accept;
  logic [1:0]               w_type;
  logic [vaddr_width_p-1:0] w_payload_pc;
  logic [instr_width_p-1:0] w_instr;
  logic [vaddr_width_p-1:0] w_pc_step;
  logic                     w_load_record;
  logic                     w_drop;
  logic                     w_error_set;

  // Uniform flow control: any packet type waits while the slot is full and not draining.
  assign w_ready      = ~r_rec_v | bus_if.record_ready_i;
  assign w_accept     = bus_if.trace_v_i & w_ready;
  assign w_type       = bus_if.trace_data_i[trace_width_p-1 -: 2];
  assign w_payload_pc = bus_if.trace_data_i[vaddr_width_p-1:0];
  assign w_instr      = bus_if.trace_data_i[instr_width_p-1:0];
  // Low bits 2'b11 mark a full 4-byte instruction; anything else is compressed.
  assign w_pc_step    = (w_instr[1:0] == 2'b11) ? vaddr_width_p'(4) : vaddr_width_p'(2);

  // Next-state, PC update and side-effect decode for the accepted packet.
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_load_record = 1'b0;
    w_drop        = 1'b0;
    w_error_set   = 1'b0;
    if (w_accept) begin
      case (w_type)
        PKT_SYNC: begin
          w_pc_next    = w_payload_pc;
          w_state_next = ST_SYNCED;
        end
        PKT_INSTR: begin
          if (r_state == ST_SYNCED) begin
            w_load_record = 1'b1;
            w_pc_next     = r_pc + w_pc_step;
          end else begin
            w_drop = 1'b1;
          end
        end
        PKT_JUMP: begin
          if (r_state == ST_SYNCED) begin
            w_pc_next = w_payload_pc;
          end else begin
            w_drop = 1'b1;
          end
        end
        default: begin
          // Reserved type: stream is corrupt, lose sync until the next SYNC.
          w_error_set  = 1'b1;
          w_state_next = ST_UNSYNCED;
        end
      endcase
    end
  end

  // Decoder state, running PC, sequence number, error flag and drop counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_UNSYNCED;
      r_pc    <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_load_record) begin
        r_seq <= r_seq + 1'b1;
      end
      if (w_drop && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
      if (w_error_set) begin
        r_error <= 1'b1;
      end
    end
  end

  // Single output slot: a new INSTR wins over a drain, so drain+load keeps valid high.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rec_v     <= 1'b0;
      r_rec_pc    <= '0;
      r_rec_instr <= '0;
      r_rec_seq   <= '0;
    end else if (w_load_record) begin
      r_rec_v     <= 1'b1;
      r_rec_pc    <= r_pc;
      r_rec_instr <= w_instr;
      r_rec_seq   <= r_seq;
    end else if (r_rec_v && bus_if.record_ready_i) begin
      r_rec_v <= 1'b0;
    end
  end

  assign bus_if.trace_ready_o  = w_ready;
  assign bus_if.record_v_o     = r_rec_v;
  assign bus_if.record_pc_o    = r_rec_pc;
  assign bus_if.record_instr_o = r_rec_instr;
  assign bus_if.record_seq_o   = r_rec_seq;
  assign synced_o              = (r_state == ST_SYNCED);
  assign error_o               = r_error;
  assign drop_count_o          = r_drop;

endmodule

// File: tb/tb_bp_trace_decoder.sv
// Bench for bp_trace_decoder: directed vector table, hand-written handshake and
// async-reset sequences, then random traffic scored against a packet-level model.
module tb_bp_trace_decoder;

  localparam int VW = 39;
  localparam int TW = 64;
  localparam int IW = 32;
  localparam int CW = 16;

  localparam logic [1:0] T_SYNC  = 2'b00;
  localparam logic [1:0] T_INSTR = 2'b01;
  localparam logic [1:0] T_JUMP  = 2'b10;
  localparam logic [1:0] T_RES   = 2'b11;

  logic          clk;
  logic          reset_n;
  logic          synced;
  logic          error;
  logic [CW-1:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  bp_trace_decoder_if #(.vaddr_width_p(VW), .trace_width_p(TW),
                        .instr_width_p(IW), .count_width_p(CW)) bus_if ();

  bp_trace_decoder #(.vaddr_width_p(VW), .trace_width_p(TW),
                     .instr_width_p(IW), .count_width_p(CW)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus_if      (bus_if),
    .synced_o    (synced),
    .error_o     (error),
    .drop_count_o(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ptype;
    logic [61:0]   payload;
    logic          v;
    logic          rr;
    logic          exp_ready;
    logic          exp_rec_v;
    logic [VW-1:0] exp_pc;
    logic [IW-1:0] exp_instr;
    logic [CW-1:0] exp_seq;
    logic          exp_synced;
    logic          exp_err;
    logic [CW-1:0] exp_drop;
  } vec_t;

  typedef struct {
    logic [VW-1:0] pc;
    logic [IW-1:0] instr;
    logic [CW-1:0] seq;
  } rec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [1:0] t, input logic [61:0] p, input logic v,
                              input logic rr, input logic er, input logic rv,
                              input logic [VW-1:0] pc, input logic [IW-1:0] ins,
                              input logic [CW-1:0] sq, input logic sy, input logic e,
                              input logic [CW-1:0] d);
    vec_t r;
    r.ptype = t; r.payload = p; r.v = v; r.rr = rr; r.exp_ready = er; r.exp_rec_v = rv;
    r.exp_pc = pc; r.exp_instr = ins; r.exp_seq = sq; r.exp_synced = sy; r.exp_err = e;
    r.exp_drop = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; ready is sampled before the edge, outputs after.
  task automatic drive(input logic [1:0] t, input logic [61:0] p, input logic v,
                       input logic rr, output logic rdy);
    @(negedge clk);
    bus_if.trace_data_i   = {t, p};
    bus_if.trace_v_i      = v;
    bus_if.record_ready_i = rr;
    #1;
    rdy = bus_if.trace_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bus_if.trace_v_i      = 1'b0;
    bus_if.record_ready_i = 1'b1;
    bus_if.trace_data_i   = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_outputs(input string tag, input logic rv, input logic [VW-1:0] pc,
                             input logic [IW-1:0] ins, input logic [CW-1:0] sq,
                             input logic sy, input logic e, input logic [CW-1:0] d);
    chk({tag, ".record_v"}, 64'(bus_if.record_v_o), 64'(rv));
    if (rv) begin
      chk({tag, ".record_pc"}, 64'(bus_if.record_pc_o), 64'(pc));
      chk({tag, ".record_instr"}, 64'(bus_if.record_instr_o), 64'(ins));
      chk({tag, ".record_seq"}, 64'(bus_if.record_seq_o), 64'(sq));
    end
    chk({tag, ".synced"}, 64'(synced), 64'(sy));
    chk({tag, ".error"}, 64'(error), 64'(e));
    chk({tag, ".drop_count"}, 64'(drop_count), 64'(d));
  endtask

  // Packet-level reference state for the random phase.
  logic          m_synced;
  logic          m_err;
  logic [VW-1:0] m_pc;
  logic [CW-1:0] m_seq;
  logic [CW-1:0] m_drop;
  rec_t          exp_q[$];

  initial begin
    logic rdy;
    logic [1:0]  t;
    logic [61:0] p;
    logic        v, rr, exp_rdy, acc;
    rec_t        r;

    reset_n = 1'b1;
    bus_if.trace_v_i      = 1'b0;
    bus_if.record_ready_i = 1'b1;
    bus_if.trace_data_i   = '0;
    #2 reset_n = 1'b0;

    // Reset state while held in reset.
    #10;
    chk_outputs("reset", 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("reset.record_pc_zero", 64'(bus_if.record_pc_o), 64'd0);
    chk("reset.trace_ready", 64'(bus_if.trace_ready_o), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- directed vector table ----------------
    vecs[0]  = mk(T_INSTR, 62'h13,         1, 1, 1, 0, '0, '0, '0, 0, 0, 16'd1);
    vecs[1]  = mk(T_SYNC,  62'h80000000,   1, 1, 1, 0, '0, '0, '0, 1, 0, 16'd1);
    vecs[2]  = mk(T_INSTR, 62'h13,         1, 1, 1, 1, 39'h80000000, 32'h13, 16'd0, 1, 0, 16'd1);
    vecs[3]  = mk(T_INSTR, 62'h4501,       1, 1, 1, 1, 39'h80000004, 32'h4501, 16'd1, 1, 0, 16'd1);
    vecs[4]  = mk(T_INSTR, 62'h00a00093,   1, 1, 1, 1, 39'h80000006, 32'h00a00093, 16'd2, 1, 0, 16'd1);
    vecs[5]  = mk(T_JUMP,  62'h80001000,   1, 1, 1, 0, '0, '0, '0, 1, 0, 16'd1);
    vecs[6]  = mk(T_INSTR, 62'h13,         1, 1, 1, 1, 39'h80001000, 32'h13, 16'd3, 1, 0, 16'd1);
    vecs[7]  = mk(T_INSTR, 62'h13,         1, 1, 1, 1, 39'h80001004, 32'h13, 16'd4, 1, 0, 16'd1);
    vecs[8]  = mk(T_SYNC,  62'h7FFFFFFFFC, 1, 1, 1, 0, '0, '0, '0, 1, 0, 16'd1);
    vecs[9]  = mk(T_INSTR, 62'h13,         1, 1, 1, 1, 39'h7FFFFFFFFC, 32'h13, 16'd5, 1, 0, 16'd1);
    vecs[10] = mk(T_INSTR, 62'h13,         1, 1, 1, 1, 39'h0, 32'h13, 16'd6, 1, 0, 16'd1);
    vecs[11] = mk(T_RES,   62'h0,          1, 1, 1, 0, '0, '0, '0, 0, 1, 16'd1);
    vecs[12] = mk(T_INSTR, 62'h13,         1, 1, 1, 0, '0, '0, '0, 0, 1, 16'd2);
    vecs[13] = mk(T_JUMP,  62'h1000,       1, 1, 1, 0, '0, '0, '0, 0, 1, 16'd3);
    vecs[14] = mk(T_INSTR, 62'h13,         0, 1, 1, 0, '0, '0, '0, 0, 1, 16'd3);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ptype, vecs[i].payload, vecs[i].v, vecs[i].rr, rdy);
      chk($sformatf("vec%0d.trace_ready", i), 64'(rdy), 64'(vecs[i].exp_ready));
      chk_outputs($sformatf("vec%0d", i), vecs[i].exp_rec_v, vecs[i].exp_pc,
                  vecs[i].exp_instr, vecs[i].exp_seq, vecs[i].exp_synced,
                  vecs[i].exp_err, vecs[i].exp_drop);
      $display("vec %0d: type=%0d payload=0x%0h rec_v=%0b pc=0x%0h seq=%0d synced=%0b err=%0b drop=%0d",
               i, vecs[i].ptype, vecs[i].payload, bus_if.record_v_o, bus_if.record_pc_o,
               bus_if.record_seq_o, synced, error, drop_count);
    end

    // ---------------- backpressure: stall, then drain + reload ----------------
    reset_dut();
    drive(T_INSTR, 62'h13, 1, 1, rdy);
    chk_outputs("bp.unsynced", 1'b0, '0, '0, '0, 1'b0, 1'b0, 16'd1);
    drive(T_SYNC, 62'h100, 1, 1, rdy);
    drive(T_INSTR, 62'h13, 1, 0, rdy);
    chk("bp.load.trace_ready", 64'(rdy), 64'd1);
    chk_outputs("bp.load", 1'b1, 39'h100, 32'h13, 16'd0, 1'b1, 1'b0, 16'd1);
    for (int k = 0; k < 3; k++) begin
      drive(T_INSTR, 62'h4501, 1, 0, rdy);
      chk($sformatf("bp.stall%0d.trace_ready", k), 64'(rdy), 64'd0);
      chk_outputs($sformatf("bp.stall%0d", k), 1'b1, 39'h100, 32'h13, 16'd0, 1'b1, 1'b0, 16'd1);
      $display("stall %0d: trace_ready=%0b rec_pc=0x%0h", k, rdy, bus_if.record_pc_o);
    end
    drive(T_INSTR, 62'h4501, 1, 1, rdy);
    chk("bp.reload.trace_ready", 64'(rdy), 64'd1);
    chk_outputs("bp.reload", 1'b1, 39'h104, 32'h4501, 16'd1, 1'b1, 1'b0, 16'd1);
    drive(T_SYNC, 62'h0, 0, 0, rdy);
    chk_outputs("bp.hold", 1'b1, 39'h104, 32'h4501, 16'd1, 1'b1, 1'b0, 16'd1);
    $display("reload: rec_v=%0b pc=0x%0h seq=%0d", bus_if.record_v_o, bus_if.record_pc_o,
             bus_if.record_seq_o);

    // ---------------- asynchronous reset while a record is pending ----------------
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_outputs("areset", 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("areset.record_pc", 64'(bus_if.record_pc_o), 64'd0);
    chk("areset.record_instr", 64'(bus_if.record_instr_o), 64'd0);
    chk("areset.record_seq", 64'(bus_if.record_seq_o), 64'd0);
    $display("async reset: rec_v=%0b synced=%0b drop=%0d", bus_if.record_v_o, synced, drop_count);

    // ---------------- randomized traffic vs packet-level model ----------------
    reset_dut();
    m_synced = 1'b0; m_err = 1'b0; m_pc = '0; m_seq = '0; m_drop = '0;
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 15))
        0, 1:                t = T_SYNC;
        2, 3:                t = T_JUMP;
        4:                   t = (($urandom_range(0, 3) == 0) ? T_RES : T_INSTR);
        default:             t = T_INSTR;
      endcase
      p  = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) p[38:0] = 39'h7FFFFFFFF0 | 39'($urandom_range(0, 15));
      v  = ($urandom_range(0, 4) != 0);
      rr = ($urandom_range(0, 9) < 7);

      @(negedge clk);
      bus_if.trace_data_i   = {t, p};
      bus_if.trace_v_i      = v;
      bus_if.record_ready_i = rr;
      #1;
      exp_rdy = (exp_q.size() == 0) || rr;
      chk("rnd.trace_ready", 64'(bus_if.trace_ready_o), 64'(exp_rdy));
      chk("rnd.record_v", 64'(bus_if.record_v_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("rnd.record_pc", 64'(bus_if.record_pc_o), 64'(exp_q[0].pc));
        chk("rnd.record_instr", 64'(bus_if.record_instr_o), 64'(exp_q[0].instr));
        chk("rnd.record_seq", 64'(bus_if.record_seq_o), 64'(exp_q[0].seq));
        if (rr) begin
          $display("rnd record: pc=0x%0h instr=0x%0h seq=%0d", bus_if.record_pc_o,
                   bus_if.record_instr_o, bus_if.record_seq_o);
        end
      end
      chk("rnd.synced", 64'(synced), 64'(m_synced));
      chk("rnd.error", 64'(error), 64'(m_err));
      chk("rnd.drop_count", 64'(drop_count), 64'(m_drop));

      acc = v && exp_rdy;
      @(posedge clk);
      if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
      if (acc) begin
        case (t)
          T_SYNC: begin
            m_pc = p[VW-1:0];
            m_synced = 1'b1;
          end
          T_INSTR: begin
            if (m_synced) begin
              r.pc = m_pc; r.instr = p[IW-1:0]; r.seq = m_seq;
              exp_q.push_back(r);
              m_seq = m_seq + 16'd1;
              m_pc  = m_pc + ((p[1:0] == 2'b11) ? 39'd4 : 39'd2);
            end else if (m_drop != 16'hFFFF) begin
              m_drop = m_drop + 16'd1;
            end
          end
          T_JUMP: begin
            if (m_synced) m_pc = p[VW-1:0];
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
          default: begin
            m_err = 1'b1;
            m_synced = 1'b0;
          end
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_trace_decoder.md
# bp_trace_decoder

Receiving end of the BlackParrot commit-trace path: consumes 64-bit trace packets drained from the trace FIFO and rebuilds the committed-instruction stream as (PC, instruction) records. Tracks a running PC that SYNC/JUMP packets set and INSTR packets advance. Sits on the host/debug side of the trace FIFO and feeds trace checkers or loggers through a valid/ready record port.

## Interface
Parameters:
- vaddr_width_p, 39, virtual PC width
- trace_width_p, 64, trace packet width; must be ≥ max(vaddr_width_p, instr_width_p) + 2
- instr_width_p, 32, instruction field width
- count_width_p, 16, width of sequence and drop counters

Ports:
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- trace_data_i  in  trace_width_p  packet from trace FIFO
- trace_v_i  in  1  packet valid
- trace_ready_o  out  1  decoder accepts packet this cycle
- record_pc_o  out  vaddr_width_p  PC of the reconstructed instruction
- record_instr_o  out  instr_width_p  instruction bits
- record_seq_o  out  count_width_p  record sequence number, starts at 0
- record_v_o  out  1  record valid
- record_ready_i  in  1  downstream consumes record
- synced_o  out  1  decoder holds a valid PC
- error_o  out  1  sticky: reserved packet type seen
- drop_count_o  out  count_width_p  saturating count of packets discarded while unsynced

## Operation
- Packet type = trace_data_i[trace_width_p-1 -: 2]. Payload: PC = data[vaddr_width_p-1:0], instr = data[instr_width_p-1:0].
  - 2'b00 SYNC: pc_r ← payload PC; state → SYNCED. No record.
  - 2'b01 INSTR: if SYNCED, load record {pc_r, instr, seq_r}, seq_r+1, pc_r ← pc_r + (instr[1:0]==2'b11 ? 4 : 2). If UNSYNCED, drop.
  - 2'b10 JUMP: if SYNCED, pc_r ← payload PC, no record. If UNSYNCED, drop (only SYNC establishes sync).
  - 2'b11 reserved: error_o ← 1 (sticky until reset), state → UNSYNCED, packet dropped (not counted in drop_count_o).
- State machine: UNSYNCED (reset) → SYNCED on SYNC; SYNCED → UNSYNCED on reserved type only; SYNC in SYNCED reloads pc_r.
- synced_o = (state == SYNCED).
- pc_r addition wraps modulo 2^vaddr_width_p. seq_r wraps modulo 2^count_width_p. drop_count_o saturates at all-ones.
- Packet acceptance: handshake = trace_v_i & trace_ready_o. trace_ready_o = ~record_v_o | record_ready_i, for every packet type (uniform flow control).
- Output is a single registered slot: set on accepted synced INSTR; cleared on record_v_o & record_ready_i with no new INSTR in the same cycle. Simultaneous drain + new INSTR: slot reloads, record_v_o stays 1.
- Record fields stable while record_v_o & ~record_ready_i.

## Timing
- Reset (reset_n_i low, async): state UNSYNCED, pc_r 0, seq_r 0, record_v_o 0, record_pc_o 0, record_instr_o 0, record_seq_o 0, synced_o 0, error_o 0, drop_count_o 0; trace_ready_o = 1 while in reset-released idle. Reset mid-record discards the pending record.
- Latency: INSTR accepted in cycle N → record_v_o high in N+1.
- SYNC/JUMP accepted in cycle N → new pc_r used by INSTR accepted in N+1 (back-to-back, no bubble).
- Throughput: one packet per cycle when record_ready_i held high.
- trace_ready_o is combinational from record_v_o and record_ready_i; no combinational path from trace_v_i.

## Test plan
- Reset then INSTR 0x00000013 before any SYNC → no record, drop_count_o=1, synced_o=0.
- SYNC pc=0x80000000, INSTRs 0x00000013, 0x4501 (compressed), 0x00a00093 → records pc 0x80000000/0x80000004/0x80000006, seq 0/1/2.
- SYNCED, JUMP pc=0x80001000 then INSTR 0x00000013 back-to-back → record pc 0x80001000; pc_r then 0x80001004.
- Hold record_ready_i=0 with record pending, trace_v_i=1 → trace_ready_o=0, record fields stable; raise record_ready_i with INSTR → drain and reload same cycle, record_v_o stays 1.
- SYNC pc=0x7FFFFFFFFC (vaddr 39 top), INSTR 4-byte → next pc_r wraps to 0x0; reserved type 2'b11 → error_o=1, synced_o=0, following INSTR dropped.
- Assert reset_n_i low asynchronously while record_v_o=1 → record_v_o falls immediately, all outputs at reset values.
